sha3_core_arbiter: RTL
======================

// Module: sha3_core_arbiter
// PURPOSE
//  Shares one SHA3/SHAKE core between N Dilithium requesters (e.g. ExpandA, ExpandS, challenge/hash).
//  Round-robin arbitration, one-cycle core start, per-job output word counting against the
//  requested output size, and a grant held until the owner releases.
//  Sits between the requester units and the core's start/output-FSM interface.
// PARAMETERS
//  N     2   number of requesters (2..8)
//  IDXW  1   owner index width, >= clog2(N)
//  W     64  core output word width in bits
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      asynchronous reset, active-high
//  req          in   N      per-requester job request, level, held until grant
//  req_outsize  in   N*11   per-requester output length in bits; slice i = [11*i+10:11*i]
//  req_done     in   N      per-requester release pulse after consuming output
//  gnt          out  N      one-hot grant, held from GRANT until release
//  owner        out  IDXW   index of current/last owner
//  core_start   out  1      one-cycle start pulse to core
//  core_outsize out  11     latched output size driven to core for whole job
//  core_eo      in   1      core output word valid (one word per high cycle)
//  core_last    in   1      core marks last output word (qualified by core_eo)
//  busy         out  1      high in any state except IDLE
//  err          out  1      sticky job error; cleared only by rst
// BEHAVIOUR
//  Reset (async): state=IDLE; gnt=0, owner=0, core_start=0, core_outsize=0, busy=0, err=0,
//   rr pointer=0, word counter=0.
//  FSM states: IDLE, GRANT, RUN, WAIT_REL.
//  IDLE: if |req, select first set bit scanning ptr, ptr+1, ... mod N; latch owner and its
//   req_outsize into core_outsize; -> GRANT next cycle. gnt[owner] rises on entering GRANT.
//  GRANT (1 cycle): expected = ceil(core_outsize/W) computed from latched size (11-bit, no wrap).
//   If core_outsize==0: err<=1, no core_start, -> WAIT_REL. Else core_start=1 this cycle, wcnt<=0, -> RUN.
//  RUN: each cycle with core_eo=1, wcnt<=wcnt+1. On core_eo & core_last: if wcnt+1 != expected,
//   err<=1; -> WAIT_REL. If core_eo & !core_last and wcnt+1 == expected, err<=1 (overrun), stay.
//   core_last without core_eo is ignored. req changes in RUN are ignored; job always completes.
//  WAIT_REL: hold gnt; on req_done[owner]=1 or req[owner]=0 -> IDLE, gnt<=0,
//   ptr<=(owner+1) mod N. req_done from non-owners ignored in every state.
//  Latency: req high in IDLE -> gnt at +1 cycle, core_start at +1 cycle (same cycle as gnt).
//   Minimum re-grant: WAIT_REL exit -> IDLE -> next gnt 2 cycles after release.
//  Fairness: with all req held, grants rotate 0,1,..,N-1,0; no requester starved.
//  core_outsize stable from GRANT through WAIT_REL; changes only on new IDLE selection.
//  Reset mid-job: all outputs return to reset values immediately; core must be reset alongside.
//  No combinational path from req/req_done to gnt or core_start; all outputs registered.
// TESTING
//  1. Single req[0], size 256, core gives 4 eo words, last on 4th -> one core_start, gnt=01
//     until req_done[0], err=0, core_outsize=256 throughout.
//  2. req=11 held, sizes 256/512, 4 jobs back to back -> owners 0,1,0,1; ptr rotates; no overlap
//     of gnt; each job exactly one core_start.
//  3. Size 100 (ceil=2): core_last on 2nd word -> err=0; repeat with last on 3rd word -> err=1
//     (overrun) and err stays 1 after later good jobs.
//  4. req_outsize=0 on owner 1 -> no core_start, err=1, gnt=10 until req_done[1], then IDLE.
//  5. req[0] dropped mid-RUN, stray req_done[1] pulses -> job completes, release occurs only
//     on WAIT_REL with req[0]=0.
//  6. rst asserted asynchronously mid-RUN (between clk edges) -> gnt/core_start/busy/err=0
//     without a clock edge; next req[1] after release is granted (ptr=0 scan).

Source files
------------

// File: rtl/sha3_core_arbiter.sv
// rtl/sha3_core_arbiter.sv - round-robin arbiter sharing one SHA3/SHAKE core between N requesters
module sha3_core_arbiter #(
   parameter int N    = 2,
   parameter int IDXW = 1,
   parameter int W    = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*11-1:0] req_outsize,
   input  logic [N-1:0]    req_done,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] owner,
   output logic            core_start,
   output logic [10:0]     core_outsize,
   input  logic            core_eo,
   input  logic            core_last,
   output logic            busy,
   output logic            err
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_GRANT    = 2'd1,
      S_RUN      = 2'd2,
      S_WAIT_REL = 2'd3
   } state_t;

   state_t          state;
   state_t          next_state;

   logic [IDXW-1:0] ptr;
   logic [IDXW-1:0] next_ptr;
   logic [11:0]     wcnt;
   logic [11:0]     wcnt_inc;
   logic [11:0]     expected;

   logic            sel_valid;
   logic            hi_valid;
   logic [IDXW-1:0] hi_idx;
   logic [IDXW-1:0] lo_idx;
   logic [IDXW-1:0] sel_idx;
   logic [N-1:0]    sel_onehot;
   logic [10:0]     sel_size;
   logic            own_req;
   logic            own_done;
   logic            release_job;

   logic [N-1:0]    gnt_d;
   logic            core_start_d;

   // Words the core must deliver: ceil(size/W), evaluated wide so size+W-1 cannot wrap.
   assign expected = 12'(({21'd0, core_outsize} + 32'(W - 1)) / 32'(W));
   assign wcnt_inc = wcnt + 12'd1;
   assign next_ptr = (owner == IDXW'(N - 1)) ? '0 : owner + IDXW'(1);

   // Round-robin pick: lowest set request at or above ptr, else lowest set request overall.
   always_comb begin
      sel_valid = 1'b0;
      hi_valid  = 1'b0;
      hi_idx    = '0;
      lo_idx    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            sel_valid = 1'b1;
            lo_idx    = IDXW'(i);
            if (i >= int'(ptr)) begin
               hi_valid = 1'b1;
               hi_idx   = IDXW'(i);
            end
         end
      end
      sel_idx = hi_valid ? hi_idx : lo_idx;
   end

   // Per-index muxes: selected requester's size/one-hot and the current owner's req/done.
   always_comb begin
      sel_size   = '0;
      sel_onehot = '0;
      own_req    = 1'b0;
      own_done   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (IDXW'(i) == sel_idx) begin
            sel_size      = req_outsize[11*i +: 11];
            sel_onehot[i] = 1'b1;
         end
         if (IDXW'(i) == owner) begin
            own_req  = req[i];
            own_done = req_done[i];
         end
      end
   end

   // The owner frees the core either by pulsing done or by dropping its request.
   assign release_job = own_done | ~own_req;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; request changes outside IDLE/WAIT_REL have no effect on the job.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (sel_valid) begin
               next_state = S_GRANT;
            end
         end
         S_GRANT: begin
            next_state = (core_outsize == 11'd0) ? S_WAIT_REL : S_RUN;
         end
         S_RUN: begin
            if (core_eo && core_last) begin
               next_state = S_WAIT_REL;
            end
         end
         S_WAIT_REL: begin
            if (release_job) begin
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Output next-values; grant and start are decided in IDLE so they appear together in GRANT.
   always_comb begin
      gnt_d        = gnt;
      core_start_d = 1'b0;
      case (state)
         S_IDLE: begin
            if (sel_valid) begin
               gnt_d        = sel_onehot;
               core_start_d = (sel_size != 11'd0);
            end
         end
         S_WAIT_REL: begin
            if (release_job) begin
               gnt_d = '0;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs so nothing combinational reaches gnt/core_start/busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt        <= '0;
         core_start <= 1'b0;
         busy       <= 1'b0;
      end else begin
         gnt        <= gnt_d;
         core_start <= core_start_d;
         busy       <= (next_state != S_IDLE);
      end
   end

   // Job datapath: owner/size latch, word counting, sticky error and pointer rotation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner        <= '0;
         core_outsize <= '0;
         ptr          <= '0;
         wcnt         <= '0;
         err          <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sel_valid) begin
                  owner        <= sel_idx;
                  core_outsize <= sel_size;
               end
            end
            S_GRANT: begin
               wcnt <= '0;
               if (core_outsize == 11'd0) begin
                  err <= 1'b1;
               end
            end
            S_RUN: begin
               if (core_eo) begin
                  wcnt <= wcnt_inc;
                  if (core_last && (wcnt_inc != expected)) begin
                     err <= 1'b1;
                  end
                  if (!core_last && (wcnt_inc == expected)) begin
                     err <= 1'b1;
                  end
               end
            end
            S_WAIT_REL: begin
               if (release_job) begin
                  ptr <= next_ptr;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
